// File: rtl/core_pkg.sv
// Shared types and encodings for the RV32I multi-cycle core.
// Sequencer states, major opcodes and datapath mux selects.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        HALT
    } seq_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic ADDR_PC   = 1'b0;
    localparam logic ADDR_ALU  = 1'b1;
    localparam logic PC_PLUS4  = 1'b0;
    localparam logic PC_TARGET = 1'b1;

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM:
                op_legal = 1'b1;
            default:
                op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Memory handshake watchdog for the multi-cycle sequencer.
// Expires on the TIMEOUT-th consecutive wait cycle; TIMEOUT=0 disables it.
module seq_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic ARMED = (TIMEOUT > 0);

    logic [TW-1:0] timer;

    assign expire = ARMED & en & (timer == LAST);

    // Count wait cycles; a state change restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (ARMED && en && !expire) begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer.
// Drives datapath strobes and the shared memory port; counts retires.
module multicycle_seq #(
    parameter int INSTRET_W = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 reg_write,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 br_cond,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 rf_we,
    output logic                 halted,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [INSTRET_W-1:0] instret
);

    import core_pkg::*;

    seq_state_t state;
    seq_state_t nxt;
    logic       take;
    logic       take_now;
    logic       retire;
    logic       wd_en;
    logic       wd_clr;
    logic       expire;

    assign take_now = jump | (branch & br_cond);
    assign wd_en    = ((state == FETCH) || (state == MEMORY)) & ~mem_ready;
    assign wd_clr   = (nxt != state);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (expire)
    );

    // Next state and strobes; strobes are held low while reset is asserted.
    always_comb begin
        nxt      = state;
        retire   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = ADDR_PC;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_PLUS4;
        rf_we    = 1'b0;
        unique case (state)
            FETCH: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_PC;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    nxt   = DECODE;
                end else if (expire) begin
                    nxt = HALT;
                end
            end
            DECODE: begin
                if (!op_legal(opcode)) begin
                    nxt = HALT;
                end else if (opcode == OP_SYSTEM) begin
                    retire = 1'b1;
                    nxt    = HALT;
                end else begin
                    nxt = EXECUTE;
                end
            end
            EXECUTE: begin
                if (mem_read || mem_write) begin
                    nxt = MEMORY;
                end else if (reg_write) begin
                    nxt = WRITEBACK;
                end else begin
                    pc_we  = 1'b1;
                    pc_sel = take_now;
                    retire = 1'b1;
                    nxt    = FETCH;
                end
            end
            MEMORY: begin
                mem_req  = 1'b1;
                mem_we   = mem_write;
                addr_sel = ADDR_ALU;
                if (mem_ready) begin
                    if (mem_read) begin
                        nxt = WRITEBACK;
                    end else begin
                        pc_we  = 1'b1;
                        pc_sel = PC_PLUS4;
                        retire = 1'b1;
                        nxt    = FETCH;
                    end
                end else if (expire) begin
                    nxt = HALT;
                end
            end
            WRITEBACK: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                pc_sel = take;
                retire = 1'b1;
                nxt    = FETCH;
            end
            HALT: begin
                nxt = HALT;
            end
            default: begin
                nxt = HALT;
            end
        endcase
        if (!rst_n) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = ADDR_PC;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pc_sel   = PC_PLUS4;
            rf_we    = 1'b0;
        end
    end

    // State, branch decision, retire counter and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            take    <= 1'b0;
            instret <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state <= nxt;
            if (state == EXECUTE) begin
                take <= take_now;
            end
            if (retire) begin
                instret <= instret + 1'b1;
            end
            if (nxt == HALT) begin
                halted <= 1'b1;
            end
            if (state == DECODE && !op_legal(opcode)) begin
                illegal <= 1'b1;
            end
            if (expire) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed scoreboard bench for multicycle_seq.
// Small counter and watchdog so wrap and timeout are reachable quickly.
module tb_multicycle_seq;

    localparam int IW = 4;
    localparam int TO = 4;

    typedef logic [13:0] vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [6:0]    opcode = '0;
    logic          reg_write = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic          branch = 1'b0;
    logic          jump = 1'b0;
    logic          br_cond = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic          addr_sel;
    logic          ir_we;
    logic          pc_we;
    logic          pc_sel;
    logic          rf_we;
    logic          halted;
    logic          illegal;
    logic          bus_err;
    logic [IW-1:0] instret;

    vec_t  sbq[$];
    string tagq[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    multicycle_seq #(
        .INSTRET_W (IW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .branch    (branch),
        .jump      (jump),
        .br_cond   (br_cond),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .rf_we     (rf_we),
        .halted    (halted),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .instret   (instret)
    );

    // {req,we,asel,ir,pcwe,pcsel,rfwe,halt,ill,berr,instret}
    function automatic vec_t e(
        input logic rq, input logic we, input logic as,
        input logic ir, input logic pw, input logic ps,
        input logic rf, input logic h, input logic il,
        input logic be, input logic [3:0] n);
        return {rq, we, as, ir, pw, ps, rf, h, il, be, n};
    endfunction

    function automatic vec_t obs();
        return {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel,
                rf_we, halted, illegal, bus_err, instret};
    endfunction

    task automatic check(input string tag, input vec_t got,
                         input vec_t want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    task automatic cyc(input string tag, input logic rdy,
                       input vec_t exp);
        vec_t  want;
        string t;
        mem_ready = rdy;
        sbq.push_back(exp);
        tagq.push_back(tag);
        @(negedge clk);
        want = sbq.pop_front();
        t    = tagq.pop_front();
        check(t, obs(), want);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("in_reset", obs(), e(0,0,0,0,0,0,0,0,0,0,4'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic rw,
                             input logic mr, input logic mw,
                             input logic br, input logic jp,
                             input logic bc);
        opcode    = op;
        reg_write = rw;
        mem_read  = mr;
        mem_write = mw;
        branch    = br;
        jump      = jp;
        br_cond   = bc;
    endtask

    initial begin
        #2;
        do_reset();

        // ALU op, zero-wait memory
        set_instr(7'b0110011, 1, 0, 0, 0, 0, 0);
        cyc("alu_F",  1, e(1,0,0,1,0,0,0,0,0,0,4'd0));
        cyc("alu_D",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("alu_E",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("alu_WB", 1, e(0,0,0,0,1,0,1,0,0,0,4'd0));
        cyc("alu_F2", 1, e(1,0,0,1,0,0,0,0,0,0,4'd1));

        // Load with two wait states in MEMORY
        do_reset();
        set_instr(7'b0000011, 1, 1, 0, 0, 0, 0);
        cyc("ld_F",  1, e(1,0,0,1,0,0,0,0,0,0,4'd0));
        cyc("ld_D",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("ld_E",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("ld_M0", 0, e(1,0,1,0,0,0,0,0,0,0,4'd0));
        cyc("ld_M1", 0, e(1,0,1,0,0,0,0,0,0,0,4'd0));
        cyc("ld_M2", 1, e(1,0,1,0,0,0,0,0,0,0,4'd0));
        cyc("ld_WB", 1, e(0,0,0,0,1,0,1,0,0,0,4'd0));
        cyc("ld_F2", 0, e(1,0,0,0,0,0,0,0,0,0,4'd1));

        // Branch taken then not taken
        do_reset();
        set_instr(7'b1100011, 0, 0, 0, 1, 0, 1);
        cyc("bt_F", 1, e(1,0,0,1,0,0,0,0,0,0,4'd0));
        cyc("bt_D", 1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("bt_E", 1, e(0,0,0,0,1,1,0,0,0,0,4'd0));
        br_cond = 1'b0;
        cyc("bn_F", 1, e(1,0,0,1,0,0,0,0,0,0,4'd1));
        cyc("bn_D", 1, e(0,0,0,0,0,0,0,0,0,0,4'd1));
        cyc("bn_E", 1, e(0,0,0,0,1,0,0,0,0,0,4'd1));
        cyc("bn_F2", 0, e(1,0,0,0,0,0,0,0,0,0,4'd2));

        // JAL: target select carried into WRITEBACK
        do_reset();
        set_instr(7'b1101111, 1, 0, 0, 0, 1, 0);
        cyc("jal_F",  1, e(1,0,0,1,0,0,0,0,0,0,4'd0));
        cyc("jal_D",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("jal_E",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        jump = 1'b0;
        cyc("jal_WB", 1, e(0,0,0,0,1,1,1,0,0,0,4'd0));

        // Store, zero-wait
        do_reset();
        set_instr(7'b0100011, 0, 0, 1, 0, 0, 0);
        cyc("st_F",  1, e(1,0,0,1,0,0,0,0,0,0,4'd0));
        cyc("st_D",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("st_E",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("st_M",  1, e(1,1,1,0,1,0,0,0,0,0,4'd0));
        cyc("st_F2", 1, e(1,0,0,1,0,0,0,0,0,0,4'd1));

        // Fetch timeout
        do_reset();
        set_instr(7'b0110011, 1, 0, 0, 0, 0, 0);
        cyc("to_W0", 0, e(1,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("to_W1", 0, e(1,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("to_W2", 0, e(1,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("to_W3", 0, e(1,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("to_H0", 1, e(0,0,0,0,0,0,0,1,0,1,4'd0));
        cyc("to_H1", 1, e(0,0,0,0,0,0,0,1,0,1,4'd0));

        // Ready on the last allowed wait cycle wins
        do_reset();
        cyc("rw_W0", 0, e(1,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("rw_W1", 0, e(1,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("rw_W2", 0, e(1,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("rw_R3", 1, e(1,0,0,1,0,0,0,0,0,0,4'd0));
        cyc("rw_D",  0, e(0,0,0,0,0,0,0,0,0,0,4'd0));

        // Illegal opcode
        do_reset();
        set_instr(7'b1111111, 0, 0, 0, 0, 0, 0);
        cyc("il_F",  1, e(1,0,0,1,0,0,0,0,0,0,4'd0));
        cyc("il_D",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("il_H0", 1, e(0,0,0,0,0,0,0,1,1,0,4'd0));
        cyc("il_H1", 1, e(0,0,0,0,0,0,0,1,1,0,4'd0));

        // ecall/ebreak
        do_reset();
        set_instr(7'b1110011, 0, 0, 0, 0, 0, 0);
        cyc("ec_F",  1, e(1,0,0,1,0,0,0,0,0,0,4'd0));
        cyc("ec_D",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("ec_H0", 1, e(0,0,0,0,0,0,0,1,0,0,4'd1));
        cyc("ec_H1", 1, e(0,0,0,0,0,0,0,1,0,0,4'd1));

        // Reset in the middle of a stalled load
        do_reset();
        set_instr(7'b0000011, 1, 1, 0, 0, 0, 0);
        cyc("mr_F",  1, e(1,0,0,1,0,0,0,0,0,0,4'd0));
        cyc("mr_D",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("mr_E",  1, e(0,0,0,0,0,0,0,0,0,0,4'd0));
        cyc("mr_M0", 0, e(1,0,1,0,0,0,0,0,0,0,4'd0));
        mem_ready = 1'b0;
        #2;
        do_reset();
        cyc("mr_F2", 1, e(1,0,0,1,0,0,0,0,0,0,4'd0));

        // Retire counter wrap
        do_reset();
        set_instr(7'b1100011, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc("wr_F", 1, e(1,0,0,1,0,0,0,0,0,0,i[3:0]));
            cyc("wr_D", 1, e(0,0,0,0,0,0,0,0,0,0,i[3:0]));
            cyc("wr_E", 1, e(0,0,0,0,1,0,0,0,0,0,i[3:0]));
        end
        cyc("wr_0", 1, e(1,0,0,1,0,0,0,0,0,0,4'd0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Multi-cycle sequencer for the RV32I core datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- It drives the datapath write strobes and the single shared instruction/data memory port, using a req/ready handshake.
- It consumes the static decode bits produced by the main control decoder.
- It counts retired instructions and halts on ecall/ebreak, illegal opcode, or memory timeout.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter.
- TIMEOUT, 16, maximum cycles mem_req may wait for mem_ready; 0 disables the watchdog.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0] from IR
- reg_write  in  1  decoder RegWrite
- mem_read  in  1  decoder MemRead
- mem_write  in  1  decoder MemWrite
- branch  in  1  decoder branch
- jump  in  1  jal/jalr indication
- br_cond  in  1  ALU branch-condition result, valid in EXECUTE
- mem_ready  in  1  memory completes the transfer this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write enable of the memory request
- addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  IR load strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  1  0 = PC+4, 1 = branch/jump target
- rf_we  out  1  register-file write strobe
- halted  out  1  sticky halt
- illegal  out  1  sticky illegal-opcode flag
- bus_err  out  1  sticky memory-timeout flag
- instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - State is FETCH.
  - take, timer, instret, halted, illegal and bus_err are all 0.
  - mem_req is high after reset release, because state is FETCH.
  - All other strobes are 0.
- Strobes are combinational from state plus mem_ready. Only state, take, timer, instret and the flags are registered.
- FETCH:
  - Outputs: mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ready=1: ir_we=1 in the same cycle, then go to DECODE. Zero-wait memory gives a 1-cycle fetch.
- DECODE: 1 cycle, during which register operands are read.
  - opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011}: set illegal, go to HALT.
  - opcode 1110011: go to HALT, with instret incremented.
  - Otherwise go to EXECUTE.
- EXECUTE: 1 cycle.
  - Latch take = jump | (branch & br_cond).
  - mem_read|mem_write: go to MEMORY.
  - Else reg_write: go to WRITEBACK.
  - Else retire: pc_we=1, pc_sel=take (computed combinationally this cycle), go to FETCH.
- MEMORY:
  - Outputs: mem_req=1, mem_we=mem_write, addr_sel=1.
  - On mem_ready with mem_read: go to WRITEBACK.
  - On mem_ready with a store: retire (pc_we=1, pc_sel=0), go to FETCH.
- WRITEBACK:
  - Outputs: rf_we=1, pc_we=1, pc_sel=take.
  - Retire, go to FETCH.
- Retire rule:
  - pc_we pulses exactly once per non-halting instruction.
  - instret increments by 1 in the retire cycle.
  - instret wraps from 2^INSTRET_W-1 to 0.
- HALT:
  - halted=1 and all strobes are 0.
  - Only reset exits HALT.
- Watchdog:
  - The timer clears on entry to FETCH or MEMORY, and increments each cycle that mem_req=1 and mem_ready=0.
  - If it reaches TIMEOUT with ready still low: set bus_err, drop mem_req next cycle, go to HALT.
  - mem_ready arriving on the same cycle the timer would expire wins: the transfer completes and bus_err is not set.
- Handshake rules:
  - mem_req, mem_we and addr_sel stay stable from assertion until the ready cycle.
  - mem_ready while mem_req=0 is ignored.
- Latency for zero-wait memory:
  - ALU op: 4 cycles.
  - Branch or store: 3 and 4 cycles respectively.
  - Load: 5 cycles.
- Reset mid-operation: all state clears immediately and asynchronously. The in-flight memory request is abandoned, and instret does not count the partial instruction.

Decomposition:
- Shared package core_pkg holds:
  - the seq_state_t enum (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT);
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM);
  - the ADDR_PC/ADDR_ALU and PC_PLUS4/PC_TARGET encodings.
- One sub-module, seq_watchdog: timer with clear, count-enable and expire outputs, parameterised by TIMEOUT.

Test Plan:
- Reset then ALU op: opcode=0110011, reg_write=1, mem_ready tied 1. Expect ir_we at cycle 0, rf_we+pc_we(pc_sel=0) at cycle 3, instret=1, mem_req high again at cycle 4.
- Load with 2 wait states in MEMORY: opcode=0000011, mem_read=1. Expect mem_req held 3 cycles with addr_sel=1, mem_we=0, then WRITEBACK rf_we=1, instret=1.
- Branch: opcode=1100011, branch=1. With br_cond=1 expect pc_we with pc_sel=1 at EXECUTE. With br_cond=0 expect pc_sel=0 and rf_we never asserted.
- TIMEOUT=4, mem_ready stuck 0 in FETCH. Expect bus_err=1 and halted=1 after 4 wait cycles, mem_req=0 thereafter, instret unchanged. mem_ready on the 4th cycle instead gives no error.
- opcode=1111111 gives illegal=1, halted=1, instret=0. opcode=1110011 gives halted=1, illegal=0, instret=1. Both are sticky until rst_n.
- Assert rst_n=0 mid-MEMORY with mem_req high. Expect mem_req to drop asynchronously before the next edge; after release, state is FETCH and instret=0. Also preload instret to all-ones (INSTRET_W=4) and retire one instruction: expect 0.
